// File: rtl/data_memory_arbiter_if.sv
// Requester and DataMemory bus bundle for data_memory_arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              p0_req;
  logic              p0_write;
  logic [ADDR_W-1:0] p0_address;
  logic [DATA_W-1:0] p0_writeData;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_readData;

  logic              p1_req;
  logic              p1_write;
  logic [ADDR_W-1:0] p1_address;
  logic [DATA_W-1:0] p1_writeData;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_readData;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic [DATA_W-1:0] mem_readData;

  logic              busy;

  modport slave (
    input  p0_req, p0_write, p0_address, p0_writeData,
    output p0_ack, p0_readData,
    input  p1_req, p1_write, p1_address, p1_writeData,
    output p1_ack, p1_readData,
    output mem_read, mem_write, mem_address, mem_writeData,
    input  mem_readData,
    output busy
  );

  modport master (
    output p0_req, p0_write, p0_address, p0_writeData,
    input  p0_ack, p0_readData,
    output p1_req, p1_write, p1_address, p1_writeData,
    input  p1_ack, p1_readData,
    input  mem_read, mem_write, mem_address, mem_writeData,
    output mem_readData,
    input  busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of single-ported DataMemory: IDLE -> ACCESS -> RESPOND.
// Define DMARB_ROUND_ROBIN_EN for round-robin contests; default is fixed priority to port 0.
module data_memory_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  state_e            state_q;
  logic              owner_q;
  logic              write_q;
  logic              last_grant_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
  logic [1:0]        ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              grant;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    grant = 1'b0;
`ifdef DMARB_ROUND_ROBIN_EN
    if (bus.p0_req && bus.p1_req) grant = ~last_grant_q;
    else                          grant = bus.p1_req;
`else
    // last_grant only shows up in the no-request case, where grant is ignored
    grant = bus.p0_req ? 1'b0 : (bus.p1_req | last_grant_q);
`endif
  end

  always_comb begin
    sel_write = grant ? bus.p1_write     : bus.p0_write;
    sel_addr  = grant ? bus.p1_address   : bus.p0_address;
    sel_wdata = grant ? bus.p1_writeData : bus.p0_writeData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            owner_q     <= grant;
            write_q     <= sel_write;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_read_q  <= ~sel_write;
            mem_write_q <= sel_write;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (!write_q) begin
            if (owner_q) rdata1_q <= bus.mem_readData;
            else         rdata0_q <= bus.mem_readData;
          end
          ack_q   <= {owner_q, ~owner_q};
          state_q <= RESPOND;
        end
        RESPOND: begin
          ack_q        <= '0;
          last_grant_q <= owner_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A reset landing in ACCESS must block the memory write in that same cycle.
  assign bus.mem_write     = mem_write_q & ~reset;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writeData = wdata_q;
  assign bus.p0_ack        = ack_q[0];
  assign bus.p1_ack        = ack_q[1];
  assign bus.p0_readData   = rdata0_q;
  assign bus.p1_readData   = rdata1_q;
  assign bus.busy          = busy_q;

endmodule
